dff_share_arbiter: RTL and testbench

//  Round-robin arbiter that shares one WIDTH-bit D-flip-flop register between N_REQ requesters.
//  The arbiter grants one requester at a time and loads that requester's data into the shared register.
//  It sits between the requesting blocks and the flip-flop bank, and owns the bank's D input and load strobe.
//  A lock lets a requester keep ownership for bursts. MAX_LOCK bounds the burst so no requester starves.

---
 rtl/dff_share_arbiter.sv | 130 +++++++++++++
 tb/tb_dff_share_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among N_REQ requesters.
// The granted requester's slice is loaded at the edge ending each grant cycle; lock extends ownership up to MAX_LOCK cycles.
module dff_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         lock,
  input  logic [N_REQ*WIDTH-1:0]   d_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_LOCK + 1);

  // Handshake: req is a level; while gnt[i] is high, req[i] high at the closing edge means d_in slice i is written.
  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              q_valid_q, q_valid_d;

  logic [OW-1:0]     rel_ptr;
  logic [OW-1:0]     arb_base;
  logic              arb_found;
  logic [OW-1:0]     arb_idx;
  logic              owner_req;

  // Winner is the first requesting index at or after base, wrapping N_REQ-1 -> 0.
  function automatic logic [OW:0] arb(input logic [N_REQ-1:0] r, input logic [OW-1:0] base);
    logic [OW:0] res;
    int          idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (r[idx]) res = {1'b1, OW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    rel_ptr   = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
    arb_base  = (state_q == OWN) ? rel_ptr : ptr_q;
    {arb_found, arb_idx} = arb(req, arb_base);
    owner_req = req[owner_q];

    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = OWN;
          owner_d = arb_idx;
          gnt_d   = N_REQ'(1) << arb_idx;
          cnt_d   = CW'(1);
        end
      end
      OWN: begin
        if (owner_req) begin
          q_d       = d_in[owner_q*WIDTH +: WIDTH];
          q_valid_d = 1'b1;
        end
        if (owner_req && lock[owner_q] && (cnt_q < CW'(MAX_LOCK))) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // Release and re-arbitrate from the slot after the owner in the same edge.
          ptr_d = rel_ptr;
          if (arb_found) begin
            owner_d = arb_idx;
            gnt_d   = N_REQ'(1) << arb_idx;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = (state_q == OWN);
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Bench for dff_share_arbiter: directed scenarios plus random traffic, all checked against a behavioural model.
module tb_dff_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ML = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] d_in;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   q;
  logic           q_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, kept as plain integers.
  int m_busy, m_owner, m_ptr, m_cnt, m_q, m_qv;

  dff_share_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .d_in(d_in),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_q = 0; m_qv = 0;
  endtask

  // Grant the first requester found scanning upward from m_ptr, or go idle.
  task automatic model_grant(input logic [N-1:0] r);
    m_busy = 0;
    for (int k = 0; k < N; k++) begin
      if (m_busy == 0 && r[(m_ptr + k) % N]) begin
        m_busy  = 1;
        m_owner = (m_ptr + k) % N;
        m_cnt   = 1;
      end
    end
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    if (m_busy != 0) begin
      if (r[m_owner]) begin
        m_q  = int'(d[m_owner*W +: W]);
        m_qv = 1;
      end
      if (r[m_owner] && l[m_owner] && m_cnt < ML) begin
        m_cnt = m_cnt + 1;
      end else begin
        m_ptr = (m_owner + 1) % N;
        model_grant(r);
      end
    end else begin
      model_grant(r);
    end
  endtask

  task automatic check_outputs();
    check("gnt",     32'(gnt),     (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
    check("owner",   32'(owner),   32'(m_owner));
    check("busy",    32'(busy),    32'(m_busy));
    check("q",       32'(q),       32'(m_q));
    check("q_valid", 32'(q_valid), 32'(m_qv));
  endtask

  // Called just after a negedge; applies inputs for one cycle and checks after the edge.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    req = r; lock = l; d_in = d;
    @(posedge clk);
    model_step(r, l, d);
    @(negedge clk);
    check_outputs();
  endtask

  // Assert reset off the clock edge; optionally verify outputs clear before any edge.
  task automatic do_reset(input bit check_async);
    #2 reset = 1'b1;
    #1;
    model_reset();
    if (check_async) begin
      check("rst_gnt",     32'(gnt),     32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_q",       32'(q),       32'd0);
      check("rst_q_valid", 32'(q_valid), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
  endtask

  logic [N*W-1:0] seq_data;

  initial begin
    reset = 1'b1; req = '0; lock = '0; d_in = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_outputs();

    // Single request: grant next cycle, write at the edge closing the grant, abort when dropped.
    step(4'b0001, 4'b0000, 32'h0000_00A5);
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_qv_pre", 32'(q_valid), 32'h0);
    step(4'b0001, 4'b0000, 32'h0000_00A5);
    check("t2_q", 32'(q), 32'hA5);
    check("t2_qv", 32'(q_valid), 32'h1);
    step(4'b0000, 4'b0000, 32'h0000_00FF);
    check("t2_idle", 32'(gnt), 32'h0);
    check("t2_q_hold", 32'(q), 32'hA5);

    // All requesting, no lock: grants rotate with no idle gap, q one cycle behind.
    do_reset(1'b0);
    seq_data = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 4'b0000, seq_data);
      check("t3_gnt", 32'(gnt), 32'd1 << (k % 4));
      if (k > 0) check("t3_q", 32'(q), 32'h10 + 32'((k - 1) % 4));
    end

    // Lock bounded by MAX_LOCK: four cycles for 0, one for 1, then back to 0.
    do_reset(1'b0);
    for (int k = 0; k < 6; k++) begin
      step(4'b0011, 4'b0001, 32'h0000_2211);
      check("t4_gnt", 32'(gnt), (k < 4) ? 32'h1 : ((k == 4) ? 32'h2 : 32'h1));
    end

    // Owner drops req during its grant: no write, next pending requester granted.
    do_reset(1'b0);
    step(4'b0100, 4'b0000, 32'h0033_0000);
    step(4'b0100, 4'b0000, 32'h0033_0000);
    check("t5_q_pre", 32'(q), 32'h33);
    step(4'b0010, 4'b0000, 32'h0077_0000);
    check("t5_q_hold", 32'(q), 32'h33);
    check("t5_gnt", 32'(gnt), 32'h2);

    // Pointer wrap: ptr=3 with req=1001 grants 3 then 0.
    do_reset(1'b0);
    step(4'b0100, 4'b0000, 32'h0);
    step(4'b1001, 4'b0000, 32'h0);
    check("t6_gnt3", 32'(gnt), 32'h8);
    step(4'b1001, 4'b0000, 32'h0);
    check("t6_gnt0", 32'(gnt), 32'h1);

    // Random traffic with occasional mid-run asynchronous resets.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1'b1);
      end else begin
        step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'($urandom));
      end
    end
    step(4'b1111, 4'b0000, 32'h4433_2211);
    do_reset(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
